// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan driver for a 4-digit seven-segment
// display. Each digit slot is PRESCALE cycles: a SHOW phase with one anode
// low, then BLANK_CYCLES cycles with every anode off to suppress ghosting.
// New values arrive over a valid/ready handshake into a one-entry pending
// register. They move to the display register only at a frame boundary or
// while the scanner is OFF, so a displayed number never tears.
//
// Handshake: load_ready is high exactly when the pending slot is empty. A
// transfer happens on any rising edge where load_valid && load_ready. After
// that, load_ready stays low until the pending value has moved to the display.
//
// Outputs are registered from the next-state values. As a result, they change
// on the same edge as the state they describe.
module seg_scan_driver #(
   parameter int PRESCALE     = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [3:0]  digit_code,
   output logic [3:0]  anode,
   output logic        frame_done
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   logic [1:0]    state, state_n;
   logic [1:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   disp, disp_n;
   logic [15:0]   pend, pend_n;
   logic          full, full_n;
   logic          boundary;
   logic          accept;

   // Next-state logic: scan sequencing, pending->display transfer, load capture
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      cnt_n    = cnt;
      disp_n   = disp;
      pend_n   = pend;
      full_n   = full;
      boundary = 1'b0;
      accept   = load_valid && !full;

      case (state)
         ST_OFF: begin
            // While dark, a waiting value is applied right away
            if (full) begin
               disp_n = pend;
               full_n = 1'b0;
            end
            if (enable) begin
               state_n = ST_SHOW;
               idx_n   = 2'd0;
               cnt_n   = '0;
            end
         end
         ST_SHOW: begin
            if (!enable) begin
               state_n = ST_OFF;
               idx_n   = 2'd0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               if (cnt == SHOW_LAST) begin
                  state_n = ST_BLANK;
               end
            end
         end
         ST_BLANK: begin
            if (!enable) begin
               state_n = ST_OFF;
               idx_n   = 2'd0;
               cnt_n   = '0;
            end else if (cnt == SLOT_LAST) begin
               state_n = ST_SHOW;
               cnt_n   = '0;
               idx_n   = idx + 2'd1;
               // End of digit 3's blank is the frame boundary
               if (idx == 2'd3) begin
                  boundary = 1'b1;
                  if (full) begin
                     disp_n = pend;
                     full_n = 1'b0;
                  end
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_OFF;
            idx_n   = 2'd0;
            cnt_n   = '0;
         end
      endcase

      // A load can only land in an empty slot, so it never collides with a transfer
      if (accept) begin
         pend_n = load_data;
         full_n = 1'b1;
      end
   end

   // State, storage and registered outputs with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_OFF;
         idx        <= 2'd0;
         cnt        <= '0;
         disp       <= 16'h0000;
         pend       <= 16'h0000;
         full       <= 1'b0;
         anode      <= 4'b1111;
         digit_code <= 4'hF;
         load_ready <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         disp       <= disp_n;
         pend       <= pend_n;
         full       <= full_n;
         load_ready <= !full_n;
         frame_done <= boundary;
         if (state_n == ST_SHOW) begin
            anode      <= ~(4'b0001 << idx_n);
            digit_code <= disp_n[{idx_n, 2'b00} +: 4];
         end else begin
            anode      <= 4'b1111;
            digit_code <= 4'hF;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver (PRESCALE=8,
// BLANK_CYCLES=2). A time-based reference model predicts every output on
// every cycle. Literal checks at key points pin that model down.
module tb_seg_scan_driver;

   localparam int P = 8;
   localparam int B = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic        load_ready;
   logic [3:0]  digit_code;
   logic [3:0]  anode;
   logic        frame_done;

   always #5 clk = ~clk;

   seg_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .digit_code (digit_code),
      .anode      (anode),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Scan position is elapsed cycles since scanning started. Digit and phase
   // follow from division. The pending slot is a queue of depth at most one.
   logic        m_on = 1'b0;
   int          m_t = 0;
   logic [15:0] m_disp = 16'h0000;
   logic [15:0] exp_q[$];
   logic [3:0]  e_anode = 4'b1111;
   logic [3:0]  e_code = 4'hF;
   logic        e_ready = 1'b1;
   logic        e_fd = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_on = 1'b0; m_t = 0; m_disp = 16'h0000; exp_q.delete();
         e_anode = 4'b1111; e_code = 4'hF; e_ready = 1'b1; e_fd = 1'b0;
      end else begin
         logic accepted;
         int   slot;
         accepted = load_valid && (exp_q.size() == 0);
         e_fd = 1'b0;
         if (!m_on) begin
            if (exp_q.size() != 0) m_disp = exp_q.pop_front();
            if (enable) begin m_on = 1'b1; m_t = 0; end
         end else if (!enable) begin
            m_on = 1'b0;
         end else begin
            m_t++;
            if (m_t % (4 * P) == 0) begin
               e_fd = 1'b1;
               if (exp_q.size() != 0) m_disp = exp_q.pop_front();
            end
         end
         if (accepted) exp_q.push_back(load_data);
         e_ready = (exp_q.size() == 0);
         e_anode = 4'b1111;
         e_code  = 4'hF;
         if (m_on && (m_t % P) < (P - B)) begin
            slot    = (m_t / P) % 4;
            e_anode = 4'b1111 & ~(4'b0001 << slot);
            e_code  = 4'((m_disp >> (4 * slot)) & 16'h000F);
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("anode", {12'h0, anode}, {12'h0, e_anode});
         chk("digit_code", {12'h0, digit_code}, {12'h0, e_code});
         chk("load_ready", {15'h0, load_ready}, {15'h0, e_ready});
         chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
         chk("one_anode", {15'h0, ($countones(~anode) <= 1)}, 16'h0001);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit_outputs(input string name, input logic [3:0] a, input logic [3:0] c);
      chk({name, "_anode"}, {12'h0, anode}, {12'h0, a});
      chk({name, "_code"}, {12'h0, digit_code}, {12'h0, c});
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      tick(3);
      rst = 1'b0;
      // Reset state
      lit_outputs("reset", 4'b1111, 4'hF);
      chk("reset_ready", {15'h0, load_ready}, 16'h0001);
      chk("reset_fd", {15'h0, frame_done}, 16'h0000);

      // Free scan with no load: digit 0 shows 0, blanks, then digit 1
      enable = 1'b1;
      tick(1);  lit_outputs("scan_t0", 4'b1110, 4'h0);
      tick(6);  lit_outputs("scan_t6", 4'b1111, 4'hF);
      tick(2);  lit_outputs("scan_t8", 4'b1101, 4'h0);
      tick(24); lit_outputs("scan_t32", 4'b1110, 4'h0);
      chk("scan_fd32", {15'h0, frame_done}, 16'h0001);
      tick(40);

      // Load 1234 while disabled
      enable = 1'b0;
      tick(1);  lit_outputs("off", 4'b1111, 4'hF);
      load_valid = 1'b1; load_data = 16'h1234;
      tick(1);  chk("off_load_ready_low", {15'h0, load_ready}, 16'h0000);
      load_valid = 1'b0;
      tick(1);  chk("off_load_ready_high", {15'h0, load_ready}, 16'h0001);
      enable = 1'b1;
      tick(1);  lit_outputs("d1234_t0", 4'b1110, 4'h4);
      tick(8);  lit_outputs("d1234_t8", 4'b1101, 4'h3);
      tick(16); lit_outputs("d1234_t24", 4'b0111, 4'h1);

      // Mid-frame load ABCD, then a second attempt that must be ignored
      load_valid = 1'b1; load_data = 16'hABCD;
      tick(1);  chk("mid_ready_low", {15'h0, load_ready}, 16'h0000);
      load_data = 16'h5555;
      tick(1);  load_valid = 1'b0;
      lit_outputs("mid_t26", 4'b0111, 4'h1);
      tick(6);  lit_outputs("abcd_t32", 4'b1110, 4'hD);
      chk("abcd_fd", {15'h0, frame_done}, 16'h0001);
      chk("abcd_ready", {15'h0, load_ready}, 16'h0001);
      tick(24); lit_outputs("abcd_t56", 4'b0111, 4'hA);

      // Disable during SHOW of digit 2, then re-enable
      tick(25);  // t = 81: digit 2, phase 1
      lit_outputs("pre_dis", 4'b1011, 4'hB);
      enable = 1'b0;
      tick(1);  lit_outputs("dis", 4'b1111, 4'hF);
      tick(3);
      enable = 1'b1;
      tick(1);  lit_outputs("reen_t0", 4'b1110, 4'hD);
      tick(5);  lit_outputs("reen_t5", 4'b1110, 4'hD);
      tick(1);  lit_outputs("reen_t6", 4'b1111, 4'hF);

      // Asynchronous reset during SHOW of digit 1 with a pending load
      tick(2);  // t = 9
      load_valid = 1'b1; load_data = 16'h7777;
      tick(1);  load_valid = 1'b0;
      chk("pre_rst_ready", {15'h0, load_ready}, 16'h0000);
      #1 rst = 1'b1;
      #1;
      lit_outputs("async_rst", 4'b1111, 4'hF);
      chk("async_rst_ready", {15'h0, load_ready}, 16'h0001);
      tick(2);
      rst = 1'b0;
      tick(1);  lit_outputs("post_rst", 4'b1110, 4'h0);
      tick(40);
      enable = 1'b0;
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
